// File: rtl/baby_display_pkg.sv
// rtl/baby_display_pkg.sv - shared types and constants for the Baby display overlay
package baby_display_pkg;

    // Glyph ROM select encoding as seen on glyph_sel
    typedef enum logic [1:0] {
        GS_CI   = 2'd0,
        GS_PI   = 2'd1,
        GS_ACC  = 2'd2,
        GS_NONE = 2'd3
    } glyph_sel_t;

    localparam int GLYPH_W = 32;
    localparam int GLYPH_H = 16;

    // Default label placement on the raster
    localparam int unsigned DEF_LABEL_X0 = 16;
    localparam int unsigned DEF_CI_Y0    = 32;
    localparam int unsigned DEF_PI_Y0    = 96;
    localparam int unsigned DEF_ACC_Y0   = 160;

endpackage

// File: rtl/baby_label_band_decode.sv
// rtl/baby_label_band_decode.sv - combinational vpos to (band select, glyph row) priority decoder
//
// Ports:
//   vpos_i  raster line
//   sel_o   live band (CI > PI > ACC on overlap), GS_NONE when no band is live
//   row_o   glyph row within the live band, 0 when no band is live
module baby_label_band_decode
    import baby_display_pkg::*;
#(
    parameter int unsigned CI_Y0      = DEF_CI_Y0,
    parameter int unsigned PI_Y0      = DEF_PI_Y0,
    parameter int unsigned ACC_Y0     = DEF_ACC_Y0,
    parameter int unsigned SCALE_LOG2 = 1
) (
    input  logic [10:0] vpos_i,
    output glyph_sel_t  sel_o,
    output logic [3:0]  row_o
);

    localparam logic [10:0] BAND_H = 11'(GLYPH_H << SCALE_LOG2);

    // 11-bit offsets: a line above the band wraps to a large value and
    // therefore fails the single unsigned range compare below.
    logic [10:0] ci_off;
    logic [10:0] pi_off;
    logic [10:0] acc_off;

    assign ci_off  = vpos_i - 11'(CI_Y0);
    assign pi_off  = vpos_i - 11'(PI_Y0);
    assign acc_off = vpos_i - 11'(ACC_Y0);

    always_comb begin
        sel_o = GS_NONE;
        row_o = 4'd0;
        if (ci_off < BAND_H) begin
            sel_o = GS_CI;
            row_o = 4'(ci_off >> SCALE_LOG2);
        end else if (pi_off < BAND_H) begin
            sel_o = GS_PI;
            row_o = 4'(pi_off >> SCALE_LOG2);
        end else if (acc_off < BAND_H) begin
            sel_o = GS_ACC;
            row_o = 4'(acc_off >> SCALE_LOG2);
        end
    end

endmodule

// File: rtl/baby_label_scheduler.sv
// rtl/baby_label_scheduler.sv - sequences CI/PI/ACC label glyphs onto the VGA raster
//
// Ports:
//   clk, rst_n                      pixel clock, async active-low reset
//   overlay_en                      label enable, sampled at hpos==0
//   hpos, vpos                      raster position
//   active_in, hsync_in, vsync_in   raster timing in
//   glyph_x/y/sel/half              glyph ROM address and select
//   glyph_pixell, glyph_pixelr      ROM data back (combinational on address)
//   overlay_pixel                   label pixel, aligned with *_out
//   active_out, hsync_out, vsync_out  timing delayed 2 cycles
module baby_label_scheduler
    import baby_display_pkg::*;
#(
    parameter int unsigned LABEL_X0   = DEF_LABEL_X0,
    parameter int unsigned CI_Y0      = DEF_CI_Y0,
    parameter int unsigned PI_Y0      = DEF_PI_Y0,
    parameter int unsigned ACC_Y0     = DEF_ACC_Y0,
    parameter int unsigned SCALE_LOG2 = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        overlay_en,
    input  logic [10:0] hpos,
    input  logic [10:0] vpos,
    input  logic        active_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [3:0]  glyph_x,
    output logic [3:0]  glyph_y,
    output logic [1:0]  glyph_sel,
    output logic        glyph_half,
    input  logic        glyph_pixell,
    input  logic        glyph_pixelr,
    output logic        overlay_pixel,
    output logic        active_out,
    output logic        hsync_out,
    output logic        vsync_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DRAW = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] SUB_MAX  = 2'((1 << SCALE_LOG2) - 1);
    localparam logic [4:0] COL_LAST = 5'(GLYPH_W - 1);

    logic [1:0] state_q, state_d;
    logic [4:0] col_q, col_d;
    logic [1:0] sub_q, sub_d;
    glyph_sel_t sel_q, sel_d;
    logic [3:0] row_q, row_d;
    logic       pix_q;
    logic [1:0] act_pipe_q;
    logic [1:0] hs_pipe_q;
    logic [1:0] vs_pipe_q;

    glyph_sel_t dec_sel;
    logic [3:0] dec_row;
    logic       line_start;
    logic       sub_wrap;

    baby_label_band_decode #(
        .CI_Y0      (CI_Y0),
        .PI_Y0      (PI_Y0),
        .ACC_Y0     (ACC_Y0),
        .SCALE_LOG2 (SCALE_LOG2)
    ) u_band_decode (
        .vpos_i (vpos),
        .sel_o  (dec_sel),
        .row_o  (dec_row)
    );

    assign line_start = (hpos == 11'd0);
    assign sub_wrap   = (sub_q == SUB_MAX);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        sub_d   = sub_q;
        sel_d   = sel_q;
        row_d   = row_q;
        if (line_start) begin
            // Line start wins over everything, so a short line can never
            // leave a half-drawn label running into the next one.
            state_d = ST_IDLE;
            col_d   = 5'd0;
            sub_d   = 2'd0;
            sel_d   = overlay_en ? dec_sel : GS_NONE;
            row_d   = overlay_en ? dec_row : 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hpos == 11'(LABEL_X0) && sel_q != GS_NONE && active_in) begin
                        state_d = ST_DRAW;
                        col_d   = 5'd0;
                        sub_d   = 2'd0;
                    end
                end
                ST_DRAW: begin
                    if (!active_in) begin
                        state_d = ST_DONE;
                    end else if (sub_wrap) begin
                        sub_d = 2'd0;
                        col_d = col_q + 5'd1;
                        if (col_q == COL_LAST) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        sub_d = sub_q + 2'd1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            col_q      <= 5'd0;
            sub_q      <= 2'd0;
            sel_q      <= GS_NONE;
            row_q      <= 4'd0;
            pix_q      <= 1'b0;
            act_pipe_q <= 2'b00;
            hs_pipe_q  <= 2'b11;
            vs_pipe_q  <= 2'b11;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            sub_q      <= sub_d;
            sel_q      <= sel_d;
            row_q      <= row_d;
            // ROM data reflects the address registered last cycle, so gating
            // with the current DRAW state keeps pixel and address in step.
            pix_q      <= (state_q == ST_DRAW) & (col_q[4] ? glyph_pixelr : glyph_pixell);
            act_pipe_q <= {act_pipe_q[0], active_in};
            hs_pipe_q  <= {hs_pipe_q[0], hsync_in};
            vs_pipe_q  <= {vs_pipe_q[0], vsync_in};
        end
    end

    assign glyph_x       = col_q[3:0];
    assign glyph_half    = col_q[4];
    assign glyph_y       = row_q;
    assign glyph_sel     = sel_q;
    assign overlay_pixel = pix_q;
    assign active_out    = act_pipe_q[1];
    assign hsync_out     = hs_pipe_q[1];
    assign vsync_out     = vs_pipe_q[1];

endmodule

// File: tb/tb_baby_label_scheduler.sv
// tb/tb_baby_label_scheduler.sv - randomized scoreboard bench for baby_label_scheduler
module tb_baby_label_scheduler;

    localparam int X0    = 16;
    localparam int CI_Y  = 32;
    localparam int PI_Y  = 36;
    localparam int ACC_Y = 160;
    localparam int SLOG  = 1;
    localparam int SCALE = 1 << SLOG;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        overlay_en;
    logic [10:0] hpos;
    logic [10:0] vpos;
    logic        active_in;
    logic        hsync_in;
    logic        vsync_in;
    logic [3:0]  glyph_x;
    logic [3:0]  glyph_y;
    logic [1:0]  glyph_sel;
    logic        glyph_half;
    logic        glyph_pixell;
    logic        glyph_pixelr;
    logic        overlay_pixel;
    logic        active_out;
    logic        hsync_out;
    logic        vsync_out;

    baby_label_scheduler #(
        .LABEL_X0   (X0),
        .CI_Y0      (CI_Y),
        .PI_Y0      (PI_Y),
        .ACC_Y0     (ACC_Y),
        .SCALE_LOG2 (SLOG)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .overlay_en    (overlay_en),
        .hpos          (hpos),
        .vpos          (vpos),
        .active_in     (active_in),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .glyph_x       (glyph_x),
        .glyph_y       (glyph_y),
        .glyph_sel     (glyph_sel),
        .glyph_half    (glyph_half),
        .glyph_pixell  (glyph_pixell),
        .glyph_pixelr  (glyph_pixelr),
        .overlay_pixel (overlay_pixel),
        .active_out    (active_out),
        .hsync_out     (hsync_out),
        .vsync_out     (vsync_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Glyph ROM model: random contents, one 32-bit row word per glyph row
    logic [31:0] rom [0:2][0:15];

    always_comb begin
        int s;
        s = int'(glyph_sel);
        glyph_pixell = 1'b0;
        glyph_pixelr = 1'b0;
        if (s < 3) begin
            glyph_pixell = rom[s][glyph_y][{1'b0, glyph_x}];
            glyph_pixelr = rom[s][glyph_y][{1'b1, glyph_x}];
        end
    end

    typedef struct {
        int due;
        bit kind;   // 0: glyph address, 1: pixel + delayed timing
        int sel;
        int y;
        bit chkx;
        int x;
        int half;
        bit pix;
        bit act;
        bit hs;
        bit vs;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    // Reference model state: what the current line should look like
    int m_sel = 3;
    int m_row = 0;
    bit m_draw = 0;
    bit m_used = 0;
    int m_n = 0;

    task automatic model_reset();
        m_sel = 3;
        m_row = 0;
        m_draw = 0;
        m_used = 0;
        m_n = 0;
    endtask

    task automatic step(input int h, input int v, input bit act, input bit hs, input bit vs, input bit en);
        exp_t g;
        exp_t p;
        int ys [3];
        hpos = 11'(h);
        vpos = 11'(v);
        active_in = act;
        hsync_in = hs;
        vsync_in = vs;
        overlay_en = en;
        ys[0] = CI_Y;
        ys[1] = PI_Y;
        ys[2] = ACC_Y;
        if (h == 0) begin
            m_sel = 3;
            m_row = 0;
            if (en) begin
                for (int k = 2; k >= 0; k--) begin
                    if (v >= ys[k] && v < ys[k] + 16 * SCALE) begin
                        m_sel = k;
                        m_row = (v - ys[k]) / SCALE;
                    end
                end
            end
            m_draw = 0;
            m_used = 0;
        end else if (m_draw) begin
            if (!act) begin
                m_draw = 0;
            end else begin
                m_n++;
                if (m_n == 32 * SCALE) m_draw = 0;
            end
        end else if (!m_used && h == X0 && m_sel != 3 && act) begin
            m_draw = 1;
            m_used = 1;
            m_n = 0;
        end
        g = '{due: cyc + 1, kind: 1'b0, sel: m_sel, y: m_row, chkx: m_draw,
              x: (m_n / SCALE) % 16, half: (m_n / SCALE) / 16,
              pix: 1'b0, act: 1'b0, hs: 1'b0, vs: 1'b0};
        p = '{due: cyc + 2, kind: 1'b1, sel: 0, y: 0, chkx: 1'b0, x: 0, half: 0,
              pix: m_draw ? rom[m_sel][m_row][m_n / SCALE] : 1'b0,
              act: act, hs: hs, vs: vs};
        sb.push_back(g);
        sb.push_back(p);
        @(posedge clk);
        #1;
    endtask

    exp_t mon_it;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_it = sb.pop_front();
            total++;
            if (mon_it.due != cyc) begin
                bad++;
                $display("FAIL missed_item cyc=%0d due=%0d", cyc, mon_it.due);
            end else if (mon_it.kind == 1'b0) begin
                if (int'(glyph_sel) != mon_it.sel || int'(glyph_y) != mon_it.y ||
                    (mon_it.chkx && (int'(glyph_x) != mon_it.x || int'(glyph_half) != mon_it.half))) begin
                    bad++;
                    $display("FAIL glyph cyc=%0d got sel=%0d y=%0d x=%0d half=%0d exp sel=%0d y=%0d x=%0d half=%0d (x checked=%0d)",
                             cyc, glyph_sel, glyph_y, glyph_x, glyph_half,
                             mon_it.sel, mon_it.y, mon_it.x, mon_it.half, mon_it.chkx);
                end
            end else begin
                if (overlay_pixel != mon_it.pix || active_out != mon_it.act ||
                    hsync_out != mon_it.hs || vsync_out != mon_it.vs) begin
                    bad++;
                    $display("FAIL pixel cyc=%0d got pix=%0b act=%0b hs=%0b vs=%0b exp pix=%0b act=%0b hs=%0b vs=%0b",
                             cyc, overlay_pixel, active_out, hsync_out, vsync_out,
                             mon_it.pix, mon_it.act, mon_it.hs, mon_it.vs);
                end
            end
        end
    end

    task automatic check_reset_values(input string name);
        total++;
        if (overlay_pixel !== 1'b0 || active_out !== 1'b0 || hsync_out !== 1'b1 ||
            vsync_out !== 1'b1 || glyph_sel !== 2'd3 || glyph_x !== 4'd0 ||
            glyph_y !== 4'd0 || glyph_half !== 1'b0) begin
            bad++;
            $display("FAIL %s got pix=%0b act=%0b hs=%0b vs=%0b sel=%0d x=%0d y=%0d half=%0b exp 0 0 1 1 3 0 0 0",
                     name, overlay_pixel, active_out, hsync_out, vsync_out,
                     glyph_sel, glyph_x, glyph_y, glyph_half);
        end
    endtask

    initial begin
        int len;
        int drop_at;
        int drop_len;
        bit en_line;
        bit act;

        for (int s = 0; s < 3; s++)
            for (int r = 0; r < 16; r++)
                rom[s][r] = $urandom;

        rst_n = 1'b0;
        overlay_en = 1'b0;
        hpos = 11'd0;
        vpos = 11'd0;
        active_in = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset_initial");
        rst_n = 1'b1;

        // Randomized raster: random syncs, random enables (also toggled
        // mid-line), occasional short lines and active_in dropouts.
        for (int ln = 0; ln < 230; ln++) begin
            len = ($urandom % 16 == 0) ? int'($urandom_range(20, 90)) : 200;
            en_line = ($urandom % 8) != 0;
            drop_at = ($urandom % 4 == 0) ? int'($urandom_range(16, 95)) : -1;
            drop_len = int'($urandom_range(1, 4));
            for (int h = 0; h < len; h++) begin
                act = (h < 150) && (ln < 215);
                if (drop_at >= 0 && h >= drop_at && h < drop_at + drop_len) act = 1'b0;
                step(h, ln, act, 1'($urandom), 1'($urandom),
                     (h == 0) ? en_line : 1'($urandom));
            end
        end

        // Reset pulsed in the middle of drawing the CI label
        for (int h = 0; h < 40; h++) step(h, CI_Y + 3, h < 150, 1'b1, 1'b1, 1'b1);
        #1;
        rst_n = 1'b0;
        sb.delete();
        model_reset();
        #1;
        check_reset_values("reset_mid_draw");
        @(posedge clk);
        #1;
        check_reset_values("reset_held");
        rst_n = 1'b1;
        for (int h = 40; h < 200; h++) step(h, CI_Y + 3, h < 150, 1'b1, 1'b1, 1'b1);
        for (int h = 0; h < 200; h++) step(h, CI_Y + 4, h < 150, 1'b0, 1'b1, 1'b1);
        for (int h = 0; h < 4; h++) step(h, CI_Y + 5, 1'b0, 1'b1, 1'b1, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
